// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl: sequencer for the multiply/divide unit that owns HI/LO.
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX. It computes the result into
// a shadow pair and holds a fixed-length busy window. The committed HI/LO
// pair updates only on the final busy edge.
//
// Ports:
//   clk     - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   start   - EX holds a valid MD instruction
//   md_op   - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   rs_val  - rs operand (multiplicand / dividend / MT source)
//   rt_val  - rt operand (multiplier / divisor)
//   is_mf   - EX holds MFHI/MFLO
//   busy    - operation in flight
//   stall   - freeze IF/ID/EX (combinational)
//   hi, lo  - committed HI/LO
module hilo_md_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        is_mf,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [31:0]       shadow_hi_q, shadow_hi_d;
   logic [31:0]       shadow_lo_q, shadow_lo_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       lo_q, lo_d;

   // Multiply: sign-extend for MULT, zero-extend for MULTU.
   logic signed [63:0] rs_sx, rt_sx;
   logic [63:0]        prod;

   always_comb begin
      rs_sx = {{32{rs_val[31]}}, rs_val};
      rt_sx = {{32{rt_val[31]}}, rt_val};
      if (md_op[0]) begin
         prod = {32'd0, rs_val} * {32'd0, rt_val};
      end else begin
         prod = rs_sx * rt_sx;
      end
   end

   // Divide by magnitudes, then restore signs. This truncates toward zero and
   // gives the remainder the dividend's sign. The 8000_0000 / FFFF_FFFF case
   // falls out as quotient 8000_0000, remainder 0, without special handling.
   logic        rs_neg, rt_neg;
   logic [31:0] rs_mag, rt_mag, rt_safe, q_mag, r_mag;
   logic [31:0] div_hi, div_lo;

   always_comb begin
      rs_neg  = ~md_op[0] & rs_val[31];
      rt_neg  = ~md_op[0] & rt_val[31];
      rs_mag  = rs_neg ? (~rs_val + 32'd1) : rs_val;
      rt_mag  = rt_neg ? (~rt_val + 32'd1) : rt_val;
      rt_safe = (rt_mag == 32'd0) ? 32'd1 : rt_mag;
      q_mag   = rs_mag / rt_safe;
      r_mag   = rs_mag % rt_safe;
      if (rt_val == 32'd0) begin
         div_lo = 32'hFFFF_FFFF;
         div_hi = rs_val;
      end else begin
         div_lo = (rs_neg ^ rt_neg) ? (~q_mag + 32'd1) : q_mag;
         div_hi = rs_neg ? (~r_mag + 32'd1) : r_mag;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shadow_hi_d = shadow_hi_q;
      shadow_lo_d = shadow_lo_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               case (md_op)
                  3'b000, 3'b001: begin
                     shadow_hi_d = prod[63:32];
                     shadow_lo_d = prod[31:0];
                     cnt_d       = CntW'(MULT_CYCLES - 1);
                     state_d     = StBusy;
                  end
                  3'b010, 3'b011: begin
                     shadow_hi_d = div_hi;
                     shadow_lo_d = div_lo;
                     cnt_d       = CntW'(DIV_CYCLES - 1);
                     state_d     = StBusy;
                  end
                  3'b100:  hi_d = rs_val;
                  3'b101:  lo_d = rs_val;
                  default: ;
               endcase
            end
         end
         StBusy: begin
            // New requests are ignored here; stall keeps them in EX.
            if (cnt_q == '0) begin
               hi_d    = shadow_hi_q;
               lo_d    = shadow_lo_q;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         shadow_hi_q <= '0;
         shadow_lo_q <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shadow_hi_q <= shadow_hi_d;
         shadow_lo_q <= shadow_lo_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
      end
   end

   assign busy  = (state_q == StBusy);
   assign stall = busy & (start | is_mf);
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule

// File: tb/tb_hilo_md_ctrl.sv
module tb_hilo_md_ctrl;

   localparam int MultN = 5;
   localparam int DivN  = 10;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] rs_val, rt_val;
   logic        is_mf;
   logic        busy, stall;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   logic [31:0] cur_hi, cur_lo;

   hilo_md_ctrl #(.MULT_CYCLES(MultN), .DIV_CYCLES(DivN)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .md_op   (md_op),
      .rs_val  (rs_val),
      .rt_val  (rt_val),
      .is_mf   (is_mf),
      .busy    (busy),
      .stall   (stall),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          cycles;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{"mult_neg",   3'b000, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, MultN};
      vecs[1]  = '{"multu_max",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MultN};
      vecs[2]  = '{"div_neg",    3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DivN};
      vecs[3]  = '{"divu_zero",  3'b011, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, DivN};
      vecs[4]  = '{"div_ovf",    3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, DivN};
      vecs[5]  = '{"divu_100_7", 3'b011, 32'd100,       32'd7,         32'd2,         32'd14,        DivN};
      vecs[6]  = '{"div_negrt",  3'b010, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, DivN};
      vecs[7]  = '{"multu_2p32", 3'b001, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         MultN};
      vecs[8]  = '{"mthi",       3'b100, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'd0,         0};
      vecs[9]  = '{"mtlo",       3'b101, 32'hDEAD_BEEF, 32'd9,         32'h1234_5678, 32'hDEAD_BEEF, 0};
      vecs[10] = '{"op110_nop",  3'b110, 32'hAAAA_AAAA, 32'd3,         32'h1234_5678, 32'hDEAD_BEEF, 0};
      vecs[11] = '{"div_zero_s", 3'b010, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, DivN};

      reset_n = 1'b0;
      start   = 1'b0;
      md_op   = 3'b000;
      rs_val  = '0;
      rt_val  = '0;
      is_mf   = 1'b0;
      cur_hi  = '0;
      cur_lo  = '0;

      #12;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      tick();
      reset_n = 1'b1;
      tick();

      // Table-driven operations
      foreach (vecs[v]) begin
         start  = 1'b1;
         md_op  = vecs[v].op;
         rs_val = vecs[v].rs;
         rt_val = vecs[v].rt;
         #1;
         chk({vecs[v].name, "_issue_stall"}, {31'd0, stall}, 32'd0);
         tick();
         start = 1'b0;
         for (int i = 0; i < vecs[v].cycles; i++) begin
            chk({vecs[v].name, "_busy"}, {31'd0, busy}, 32'd1);
            chk({vecs[v].name, "_hold_hi"}, hi, cur_hi);
            chk({vecs[v].name, "_hold_lo"}, lo, cur_lo);
            tick();
         end
         chk({vecs[v].name, "_done"}, {31'd0, busy}, 32'd0);
         chk({vecs[v].name, "_hi"}, hi, vecs[v].exp_hi);
         chk({vecs[v].name, "_lo"}, lo, vecs[v].exp_lo);
         cur_hi = vecs[v].exp_hi;
         cur_lo = vecs[v].exp_lo;
      end

      // MFHI/MFLO held across a MULT: stall exactly during busy
      start  = 1'b1;
      md_op  = 3'b000;
      rs_val = 32'd2;
      rt_val = 32'd3;
      tick();
      start = 1'b0;
      is_mf = 1'b1;
      #1;
      for (int i = 0; i < MultN; i++) begin
         chk("mf_stall", {31'd0, stall}, 32'd1);
         chk("mf_hold_hi", hi, cur_hi);
         chk("mf_hold_lo", lo, cur_lo);
         tick();
      end
      chk("mf_stall_end", {31'd0, stall}, 32'd0);
      chk("mf_hi", hi, 32'd0);
      chk("mf_lo", lo, 32'd6);
      is_mf  = 1'b0;
      cur_hi = 32'd0;
      cur_lo = 32'd6;

      // Start while busy is ignored (MTHI presented during the window)
      start  = 1'b1;
      md_op  = 3'b001;
      rs_val = 32'd1;
      rt_val = 32'd1;
      tick();
      md_op  = 3'b100;
      rs_val = 32'hAAAA_5555;
      #1;
      for (int i = 0; i < MultN - 1; i++) begin
         chk("busy_start_stall", {31'd0, stall}, 32'd1);
         chk("busy_start_hi", hi, cur_hi);
         tick();
      end
      start = 1'b0;
      tick();
      chk("busy_start_done", {31'd0, busy}, 32'd0);
      chk("busy_start_hi_end", hi, 32'd0);
      chk("busy_start_lo_end", lo, 32'd1);

      // Reset in the middle of a DIV: immediate clear, no late commit
      start  = 1'b1;
      md_op  = 3'b010;
      rs_val = 32'd100;
      rt_val = 32'd3;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      chk("rst_mid_busy_pre", {31'd0, busy}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_hi", hi, 32'd0);
      chk("rst_mid_lo", lo, 32'd0);
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < DivN + 3; i++) tick();
      chk("rst_late_busy", {31'd0, busy}, 32'd0);
      chk("rst_late_hi", hi, 32'd0);
      chk("rst_late_lo", lo, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
